// File: rtl/cp0_exc_seq_pkg.sv
// Shared constants for the CP0 exception/interrupt sequencer: register
// addresses, ExcCodes, Status bit positions, state and event encodings.
package cp0_exc_seq_pkg;

    // CP0 register addresses
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    // Status bit indices and the EXL mask used by the read-modify-write
    localparam int unsigned ST_IE  = 0;
    localparam int unsigned ST_EXL = 1;
    localparam logic [31:0] EXL_MASK = 32'h0000_0002;

    // Sequencer states; the state names the write on the outputs this cycle
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WR_EPC    = 2'd1;
    localparam logic [1:0] S_WR_CAUSE  = 2'd2;
    localparam logic [1:0] S_WR_STATUS = 2'd3;

    // Arbitrated event kind
    typedef enum logic [1:0] {
        EVT_NONE,
        EVT_INT,
        EVT_EXC,
        EVT_ERET
    } evt_kind_t;

    // Restart address: a delay-slot instruction restarts at its branch
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cp0_exc_seq.sv
// CP0 exception/interrupt sequencer: arbitrates interrupt / exception / ERET
// from the MEM stage, issues a one-cycle flush with redirect PC, then walks
// the EPC, CAUSE and STATUS updates through the single CP0 write port.
module cp0_exc_seq #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int unsigned INT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_pc_i,
    input  logic        in_delayslot_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_code_i,
    input  logic        is_eret_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_data_o,
    output logic        cp0_exc_o
);
    import cp0_exc_seq_pkg::*;

    logic [1:0]  state, state_nx;
    evt_kind_t   evt;
    logic        int_pend;

    // Latched context for the CAUSE and STATUS writes
    logic [4:0]  code_r;
    logic        bd_r;
    logic [31:0] status_r;
    logic [23:0] cause_mid_r;   // cause[30:7]
    logic [1:0]  cause_lo_r;    // cause[1:0]

    logic        flush_nx, we_nx, busy_nx;
    logic [31:0] pc_nx, data_nx;
    logic [4:0]  waddr_nx;

    // Cause bits replaced wholesale by the sequencer are never read
    logic unused_cause;
    assign unused_cause = &{1'b0, cause_i[31], cause_i[6:2]};

    // Arbitrate the MEM-stage request: interrupt > exception > ERET
    always_comb begin
        int_pend = (|(cause_i[9:8] & status_i[9:8])) |
                   (|(cause_i[10 +: INT_W] & status_i[10 +: INT_W]));
        evt = EVT_NONE;
        if (inst_valid_i) begin
            if (status_i[ST_IE] && !status_i[ST_EXL] && int_pend)
                evt = EVT_INT;
            else if (exc_valid_i)
                evt = EVT_EXC;
            else if (is_eret_i)
                evt = EVT_ERET;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_nx = state;
        flush_nx = 1'b0;
        pc_nx    = '0;
        we_nx    = 1'b0;
        waddr_nx = '0;
        data_nx  = '0;
        case (state)
            S_IDLE: begin
                if (evt == EVT_INT || evt == EVT_EXC) begin
                    state_nx = S_WR_EPC;
                    flush_nx = 1'b1;
                    pc_nx    = EXC_VECTOR;
                    we_nx    = 1'b1;
                    waddr_nx = CP0_EPC;
                    data_nx  = epc_of(inst_pc_i, in_delayslot_i);
                end else if (evt == EVT_ERET) begin
                    state_nx = S_WR_STATUS;
                    flush_nx = 1'b1;
                    pc_nx    = epc_i;
                    we_nx    = 1'b1;
                    waddr_nx = CP0_STATUS;
                    data_nx  = status_i & ~EXL_MASK;
                end
            end
            S_WR_EPC: begin
                state_nx = S_WR_CAUSE;
                we_nx    = 1'b1;
                waddr_nx = CP0_CAUSE;
                data_nx  = {bd_r, cause_mid_r, code_r, cause_lo_r};
            end
            S_WR_CAUSE: begin
                state_nx = S_WR_STATUS;
                we_nx    = 1'b1;
                waddr_nx = CP0_STATUS;
                data_nx  = status_r | EXL_MASK;
            end
            S_WR_STATUS: state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

    // State, registered outputs and latched context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            flush_o     <= 1'b0;
            new_pc_o    <= '0;
            busy_o      <= 1'b0;
            cp0_we_o    <= 1'b0;
            cp0_waddr_o <= '0;
            cp0_data_o  <= '0;
            code_r      <= '0;
            bd_r        <= 1'b0;
            status_r    <= '0;
            cause_mid_r <= '0;
            cause_lo_r  <= '0;
        end else begin
            state       <= state_nx;
            flush_o     <= flush_nx;
            new_pc_o    <= pc_nx;
            busy_o      <= busy_nx;
            cp0_we_o    <= we_nx;
            cp0_waddr_o <= waddr_nx;
            cp0_data_o  <= data_nx;
            if (state == S_IDLE && (evt == EVT_INT || evt == EVT_EXC)) begin
                code_r      <= (evt == EVT_INT) ? EXC_INT : exc_code_i;
                bd_r        <= in_delayslot_i;
                status_r    <= status_i;
                cause_mid_r <= cause_i[30:7];
                cause_lo_r  <= cause_i[1:0];
            end
        end
    end

    assign cp0_exc_o = cp0_we_o;

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Self-checking bench for cp0_exc_seq: directed scenarios with literal
// expectations plus randomized traffic against a queue-based event model.
module tb_cp0_exc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i;
    logic [31:0] inst_pc_i;
    logic        in_delayslot_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic        is_eret_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;
    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_data_o;
    logic        cp0_exc_o;

    cp0_exc_seq #(.EXC_VECTOR(32'h0000_0020), .INT_W(6)) dut (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid_i), .inst_pc_i(inst_pc_i),
        .in_delayslot_i(in_delayslot_i), .exc_valid_i(exc_valid_i),
        .exc_code_i(exc_code_i), .is_eret_i(is_eret_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
        .flush_o(flush_o), .new_pc_o(new_pc_o), .busy_o(busy_o),
        .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o),
        .cp0_data_o(cp0_data_o), .cp0_exc_o(cp0_exc_o)
    );

    always #5 clk = ~clk;

    // One expected output cycle; anything not queued is an all-zero idle cycle
    typedef struct {
        logic        flush;
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   idle_now = 1'b0;

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic push_e(input logic f, input logic [31:0] pc, input logic [4:0] addr,
                          input logic [31:0] data);
        exp_t e;
        e.flush = f; e.pc = pc; e.addr = addr; e.data = data;
        expq.push_back(e);
    endtask

    // Architectural model: decide the event from this cycle's inputs and
    // queue the cycles of outputs it must produce.
    task automatic model_detect();
        bit          pend, take_int;
        logic [31:0] epc, cnew;
        logic [4:0]  code;
        pend     = ((cause_i[15:8] & status_i[15:8]) != 8'h00);
        take_int = inst_valid_i && status_i[0] && !status_i[1] && pend;
        if (take_int || (inst_valid_i && exc_valid_i)) begin
            epc  = in_delayslot_i ? inst_pc_i - 32'd4 : inst_pc_i;
            code = take_int ? 5'd0 : exc_code_i;
            cnew = (cause_i & 32'h7FFF_FF83) | ({31'd0, in_delayslot_i} << 31)
                   | ({27'd0, code} << 2);
            push_e(1'b1, 32'h20, 5'd14, epc);
            push_e(1'b0, 32'h0,  5'd13, cnew);
            push_e(1'b0, 32'h0,  5'd12, status_i | 32'h2);
        end else if (inst_valid_i && is_eret_i) begin
            push_e(1'b1, epc_i, 5'd12, status_i & 32'hFFFF_FFFD);
        end
    endtask

    // Compare this cycle's outputs against the model, away from the edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        idle_now = (expq.size() == 0);
        if (idle_now) begin
            e.flush = 1'b0; e.pc = '0; e.addr = '0; e.data = '0;
        end else begin
            e = expq.pop_front();
        end
        vectors++;
        if (flush_o !== e.flush || new_pc_o !== e.pc || busy_o !== !idle_now ||
            cp0_we_o !== !idle_now || cp0_exc_o !== !idle_now ||
            cp0_waddr_o !== e.addr || cp0_data_o !== e.data) begin
            miscompares++;
            $display("FAIL model @%0t: got flush=%b pc=%h busy=%b we=%b exc=%b addr=%0d data=%h, want flush=%b pc=%h busy=%b we=%b exc=%b addr=%0d data=%h",
                     $time, flush_o, new_pc_o, busy_o, cp0_we_o, cp0_exc_o, cp0_waddr_o,
                     cp0_data_o, e.flush, e.pc, !idle_now, !idle_now, !idle_now, e.addr, e.data);
        end
    endtask

    task automatic commit();
        if (idle_now) model_detect();
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic bd, input logic ex,
                          input logic [4:0] code, input logic er, input logic [31:0] st,
                          input logic [31:0] ca, input logic [31:0] ep);
        inst_valid_i = v; inst_pc_i = pc; in_delayslot_i = bd; exc_valid_i = ex;
        exc_code_i = code; is_eret_i = er; status_i = st; cause_i = ca; epc_i = ep;
    endtask

    task automatic quiet();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic rand_in();
        logic [4:0] codes [4];
        codes[0] = 5'd8; codes[1] = 5'd9; codes[2] = 5'd10; codes[3] = 5'd12;
        inst_valid_i   = ($urandom_range(0, 3) != 0);
        inst_pc_i      = $urandom;
        in_delayslot_i = $urandom_range(0, 1) == 1;
        exc_valid_i    = ($urandom_range(0, 2) == 0);
        exc_code_i     = codes[$urandom_range(0, 3)];
        is_eret_i      = ($urandom_range(0, 3) == 0);
        status_i       = $urandom;
        cause_i        = $urandom;
        if ($urandom_range(0, 1) == 1) cause_i = cause_i & 32'hFFFF_00FF;
        epc_i          = $urandom;
    endtask

    task automatic busy_cycle();
        rand_in(); commit(); tick();
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            quiet(); commit(); tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        repeat (2) @(negedge clk);
        check_lit("reset_flush", {31'd0, flush_o}, 32'h0);
        check_lit("reset_busy", {31'd0, busy_o}, 32'h0);
        check_lit("reset_we", {31'd0, cp0_we_o}, 32'h0);
        check_lit("reset_data", cp0_data_o, 32'h0);
        rst = 1'b0;
        tick();
        idle_cycles(2);

        // Syscall
        set_in(1'b1, 32'h100, 1'b0, 1'b1, 5'd8, 1'b0, 32'h0, 32'h0, 32'h0);
        commit(); tick();
        check_lit("sys_flush", {31'd0, flush_o}, 32'h1);
        check_lit("sys_newpc", new_pc_o, 32'h20);
        check_lit("sys_epc_addr", {27'd0, cp0_waddr_o}, 32'd14);
        check_lit("sys_epc_data", cp0_data_o, 32'h100);
        busy_cycle();
        check_lit("sys_cause_data", cp0_data_o, 32'h20);
        check_lit("sys_cause_flush", {31'd0, flush_o}, 32'h0);
        busy_cycle();
        check_lit("sys_status_data", cp0_data_o, 32'h2);
        check_lit("sys_status_busy", {31'd0, busy_o}, 32'h1);
        quiet(); commit(); tick();
        check_lit("sys_done_busy", {31'd0, busy_o}, 32'h0);

        // Delay-slot overflow
        set_in(1'b1, 32'h204, 1'b1, 1'b1, 5'd12, 1'b0, 32'h0, 32'h0, 32'h0);
        commit(); tick();
        check_lit("ds_epc", cp0_data_o, 32'h200);
        busy_cycle();
        check_lit("ds_cause", cp0_data_o, 32'h8000_0030);
        busy_cycle();
        idle_cycles(1);

        // Interrupt beats a simultaneous exception
        set_in(1'b1, 32'h300, 1'b0, 1'b1, 5'd8, 1'b0, 32'h401, 32'h400, 32'h0);
        commit(); tick();
        check_lit("int_flush", {31'd0, flush_o}, 32'h1);
        busy_cycle();
        check_lit("int_cause", cp0_data_o, 32'h400);
        busy_cycle();
        check_lit("int_status", cp0_data_o, 32'h403);
        idle_cycles(1);

        // EXL masks the interrupt
        set_in(1'b1, 32'h300, 1'b0, 1'b0, 5'd0, 1'b0, 32'h403, 32'h400, 32'h0);
        commit(); tick();
        check_lit("exl_flush", {31'd0, flush_o}, 32'h0);
        check_lit("exl_we", {31'd0, cp0_we_o}, 32'h0);

        // Pending interrupt on a bubble waits for a valid instruction
        set_in(1'b0, 32'h400, 1'b0, 1'b0, 5'd0, 1'b0, 32'h401, 32'h400, 32'h0);
        commit(); tick();
        check_lit("bubble_flush", {31'd0, flush_o}, 32'h0);
        set_in(1'b1, 32'h400, 1'b0, 1'b0, 5'd0, 1'b0, 32'h401, 32'h400, 32'h0);
        commit(); tick();
        check_lit("bubble_then_flush", {31'd0, flush_o}, 32'h1);
        check_lit("bubble_then_epc", cp0_data_o, 32'h400);
        busy_cycle();
        busy_cycle();
        idle_cycles(1);

        // ERET
        set_in(1'b1, 32'h500, 1'b0, 1'b0, 5'd0, 1'b1, 32'h3, 32'h0, 32'h1234);
        commit(); tick();
        check_lit("eret_newpc", new_pc_o, 32'h1234);
        check_lit("eret_addr", {27'd0, cp0_waddr_o}, 32'd12);
        check_lit("eret_status", cp0_data_o, 32'h1);
        quiet(); commit(); tick();
        check_lit("eret_idle_busy", {31'd0, busy_o}, 32'h0);

        // Asynchronous reset in WR_CAUSE abandons the sequence
        set_in(1'b1, 32'h600, 1'b0, 1'b1, 5'd10, 1'b0, 32'h0, 32'h0, 32'h0);
        commit(); tick();
        busy_cycle();
        rst = 1'b1;
        #1;
        check_lit("rst_mid_we", {31'd0, cp0_we_o}, 32'h0);
        check_lit("rst_mid_busy", {31'd0, busy_o}, 32'h0);
        check_lit("rst_mid_data", cp0_data_o, 32'h0);
        expq.delete();
        quiet();
        #1 rst = 1'b0;
        tick();
        check_lit("rst_no_status", {31'd0, cp0_we_o}, 32'h0);
        idle_cycles(2);

        // Randomized traffic, including back-to-back events
        for (int unsigned i = 0; i < 3000; i++) begin
            rand_in(); commit(); tick();
        end
        idle_cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
